// File: rtl/fft_pp_pkg.sv
// fft_pp_pkg: shared FFT postprocess defaults and helpers
//   PP_W_IN / PP_N_BINS : chain-wide default sample width and bins per frame
//   pp_flags_t          : per-sample frame-position flags carried down a pipeline
//   acc_width()         : accumulator width that cannot overflow over n_avg frames
package fft_pp_pkg;

    localparam int PP_W_IN   = 32;
    localparam int PP_N_BINS = 256;

    typedef struct packed {
        logic first;
        logic last_frm;
        logic eof;
    } pp_flags_t;

    function automatic int acc_width(input int w_in, input int n_avg);
        return w_in + $clog2(n_avg);
    endfunction

endpackage

// File: rtl/sdp_ram.sv
// sdp_ram: simple dual-port RAM, one write and one registered read port, read-first, no reset
//   clk     : clock
//   we      : write enable for waddr/wdata
//   waddr   : write address
//   wdata   : write data
//   raddr   : read address, data appears on rd_data one cycle later
//   rd_data : registered read data (old contents on a same-address write)
module sdp_ram #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 32,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        rd_data <= mem[raddr];
    end

endmodule

// File: rtl/power_avg.sv
// power_avg: bin-wise averager of 2^LOG2_AVG consecutive FFT power frames
//   clk, rst         : clock, synchronous active-high reset
//   i_data/i_vld     : unsigned power sample per bin, gaps allowed
//   i_last           : last bin of the input frame (qualified by i_vld)
//   o_data/o_vld     : per-bin truncated average, emitted only on the last averaged frame
//   o_last           : last bin of the output frame
//   o_err            : one-cycle pulse when i_last disagrees with the bin position
module power_avg
    import fft_pp_pkg::*;
#(
    parameter int W_IN     = PP_W_IN,
    parameter int N_BINS   = PP_N_BINS,
    parameter int LOG2_AVG = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [W_IN-1:0] i_data,
    input  logic            i_vld,
    input  logic            i_last,
    output logic [W_IN-1:0] o_data,
    output logic            o_vld,
    output logic            o_last,
    output logic            o_err
);

    localparam int W_ACC = acc_width(W_IN, 1 << LOG2_AVG);
    localparam int BW    = $clog2(N_BINS);
    // frame counter keeps one bit even when no averaging is done
    localparam int FW    = (LOG2_AVG > 0) ? LOG2_AVG : 1;
    localparam logic [FW-1:0] FRM_MAX = FW'((1 << LOG2_AVG) - 1);
    localparam logic [BW-1:0] BIN_MAX = BW'(N_BINS - 1);

    logic [BW-1:0]    bin_cnt;
    logic [FW-1:0]    frm_cnt;
    logic             eob, err, take;
    pp_flags_t        flags;

    logic             s1_vld, s1_err;
    logic [W_IN-1:0]  s1_data;
    logic [BW-1:0]    s1_bin;
    pp_flags_t        s1_flags;

    logic [W_ACC-1:0] ram_rd, sum;
    logic             ram_we;

    assign eob   = bin_cnt == BIN_MAX;
    assign err   = i_vld && (i_last != eob);
    assign take  = i_vld && !err;
    assign flags = '{first: frm_cnt == '0, last_frm: frm_cnt == FRM_MAX, eof: i_last};

    // frame 0 ignores the RAM so stale contents never contribute
    assign sum    = (s1_flags.first ? '0 : ram_rd) + W_ACC'(s1_data);
    assign ram_we = s1_vld && !s1_flags.last_frm;

    sdp_ram #(.DEPTH(N_BINS), .WIDTH(W_ACC)) u_ram (
        .clk     (clk),
        .we      (ram_we),
        .waddr   (s1_bin),
        .wdata   (sum),
        .raddr   (bin_cnt),
        .rd_data (ram_rd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_cnt <= '0;
            frm_cnt <= '0;
            s1_vld  <= 1'b0;
            s1_err  <= 1'b0;
            o_data  <= '0;
            o_vld   <= 1'b0;
            o_last  <= 1'b0;
            o_err   <= 1'b0;
        end else begin
            s1_vld <= take;
            s1_err <= err;
            o_vld  <= s1_vld && s1_flags.last_frm;
            o_last <= s1_vld && s1_flags.last_frm && s1_flags.eof;
            o_err  <= s1_err;
            if (s1_vld && s1_flags.last_frm)
                o_data <= sum[W_ACC-1:LOG2_AVG];
            // a framing error abandons the partial average and restarts at bin 0 frame 0
            if (err) begin
                bin_cnt <= '0;
                frm_cnt <= '0;
            end else if (take) begin
                bin_cnt <= bin_cnt + 1'b1;
                if (eob)
                    frm_cnt <= flags.last_frm ? '0 : frm_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (take) begin
            s1_data  <= i_data;
            s1_bin   <= bin_cnt;
            s1_flags <= flags;
        end
    end

endmodule

// File: tb/tb_power_avg.sv
// tb_power_avg: scoreboard bench for power_avg with three averaging depths (2, 4, 1 frames)
module tb_power_avg;

    typedef struct {
        int          due;
        bit          err;
        logic [31:0] d;
        bit          last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          gap_pct = 0;

    logic [31:0] i_data_a [3];
    logic        i_vld_a  [3];
    logic        i_last_a [3];
    logic [31:0] o_data_a [3];
    logic        o_vld_a  [3];
    logic        o_last_a [3];
    logic        o_err_a  [3];

    exp_t            q [3][$];
    int              bin_m [3];
    int              frm_m [3];
    longint unsigned acc_m [3][4];
    int              lg [3] = '{1, 2, 0};
    exp_t            e;

    power_avg #(.W_IN(32), .N_BINS(4), .LOG2_AVG(1)) dut0 (
        .clk(clk), .rst(rst), .i_data(i_data_a[0]), .i_vld(i_vld_a[0]), .i_last(i_last_a[0]),
        .o_data(o_data_a[0]), .o_vld(o_vld_a[0]), .o_last(o_last_a[0]), .o_err(o_err_a[0]));
    power_avg #(.W_IN(32), .N_BINS(4), .LOG2_AVG(2)) dut1 (
        .clk(clk), .rst(rst), .i_data(i_data_a[1]), .i_vld(i_vld_a[1]), .i_last(i_last_a[1]),
        .o_data(o_data_a[1]), .o_vld(o_vld_a[1]), .o_last(o_last_a[1]), .o_err(o_err_a[1]));
    power_avg #(.W_IN(32), .N_BINS(4), .LOG2_AVG(0)) dut2 (
        .clk(clk), .rst(rst), .i_data(i_data_a[2]), .i_vld(i_vld_a[2]), .i_last(i_last_a[2]),
        .o_data(o_data_a[2]), .o_vld(o_vld_a[2]), .o_last(o_last_a[2]), .o_err(o_err_a[2]));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // monitor: every output event must match the oldest expected event, on its due cycle
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 3; k++) begin
                if (o_last_a[k] && !o_vld_a[k]) begin
                    total++; bad++;
                    $display("FAIL olast_alone inst%0d cyc=%0d o_last=1 o_vld=0, want o_last only with o_vld", k, cyc);
                end
                if (o_vld_a[k] || o_err_a[k]) begin
                    total++;
                    if (q[k].size() == 0) begin
                        bad++;
                        $display("FAIL unexpected inst%0d cyc=%0d got vld=%0b err=%0b data=%h, want nothing",
                                 k, cyc, o_vld_a[k], o_err_a[k], o_data_a[k]);
                    end else begin
                        e = q[k].pop_front();
                        if (e.due != cyc || e.err != o_err_a[k] || e.err == o_vld_a[k] ||
                            (!e.err && (o_data_a[k] !== e.d || o_last_a[k] !== e.last))) begin
                            bad++;
                            $display("FAIL out inst%0d got cyc=%0d vld=%0b err=%0b data=%h last=%0b, want cyc=%0d err=%0b data=%h last=%0b",
                                     k, cyc, o_vld_a[k], o_err_a[k], o_data_a[k], o_last_a[k], e.due, e.err, e.d, e.last);
                        end
                    end
                end else if (q[k].size() > 0 && q[k][0].due <= cyc) begin
                    total++; bad++;
                    e = q[k].pop_front();
                    $display("FAIL missing inst%0d cyc=%0d got no output, want err=%0b data=%h due %0d",
                             k, cyc, e.err, e.d, e.due);
                end
            end
        end
    end

    task automatic check_zero();
        for (int k = 0; k < 3; k++) begin
            total++;
            if ({o_data_a[k], o_vld_a[k], o_last_a[k], o_err_a[k]} !== 35'd0) begin
                bad++;
                $display("FAIL reset_out inst%0d got data=%h vld=%0b last=%0b err=%0b, want all 0",
                         k, o_data_a[k], o_vld_a[k], o_last_a[k], o_err_a[k]);
            end
        end
    endtask

    task automatic do_reset(int n);
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            q[k].delete();
            bin_m[k] = 0;
            frm_m[k] = 0;
        end
        check_zero();
        rst = 1'b0;
    endtask

    // reference: accumulate per bin over 2^L frames, emit sum/2^L on the last frame
    task automatic send(int k, logic [31:0] d, bit last);
        exp_t x;
        int   nf;
        while ($urandom_range(99) < gap_pct) begin
            @(posedge clk);
            #1;
        end
        nf = 1 << lg[k];
        i_data_a[k] = d;
        i_vld_a[k]  = 1'b1;
        i_last_a[k] = last;
        x.due = cyc + 2; x.err = 0; x.d = 0; x.last = 0;
        if (last != (bin_m[k] == 3)) begin
            x.err = 1;
            q[k].push_back(x);
            bin_m[k] = 0;
            frm_m[k] = 0;
        end else begin
            acc_m[k][bin_m[k]] = (frm_m[k] == 0 ? 64'd0 : acc_m[k][bin_m[k]]) + 64'(d);
            if (frm_m[k] == nf - 1) begin
                x.d    = 32'(acc_m[k][bin_m[k]] / 64'(nf));
                x.last = last;
                q[k].push_back(x);
            end
            bin_m[k]++;
            if (bin_m[k] == 4) begin
                bin_m[k] = 0;
                frm_m[k] = (frm_m[k] + 1) % nf;
            end
        end
        @(posedge clk);
        #1;
        i_vld_a[k]  = 1'b0;
        i_last_a[k] = 1'b0;
        i_data_a[k] = $urandom;
    endtask

    task automatic send_frame(int k, logic [31:0] a, logic [31:0] b, logic [31:0] c, logic [31:0] d);
        send(k, a, 0);
        send(k, b, 0);
        send(k, c, 0);
        send(k, d, 1);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            i_data_a[k] = '0;
            i_vld_a[k]  = 1'b0;
            i_last_a[k] = 1'b0;
        end
        do_reset(3);

        // two frames averaged, truncating
        send_frame(0, 10, 20, 30, 40);
        send_frame(0, 11, 21, 31, 41);

        // four full-scale frames must not overflow
        repeat (4) send_frame(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // same data as the first scenario with idle gaps
        gap_pct = 30;
        send_frame(0, 10, 20, 30, 40);
        send_frame(0, 11, 21, 31, 41);

        // i_last on bin 1: error, then restart at bin 0 frame 0
        gap_pct = 0;
        send(0, 7, 0);
        send(0, 9, 1);
        send_frame(0, 100, 200, 300, 400);
        send_frame(0, 101, 203, 305, 407);

        // reset in the middle of frame 1 with samples in flight
        send_frame(0, 1, 2, 3, 4);
        send(0, 50, 0);
        send(0, 60, 0);
        do_reset(1);
        send_frame(0, 1000, 2000, 3000, 4000);
        send_frame(0, 1001, 2001, 3001, 4003);

        // passthrough
        send_frame(2, 5, 6, 7, 8);

        // randomized traffic with occasional framing errors
        gap_pct = 30;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 80; i++)
                send(k, $urandom, ($urandom_range(99) < 5) ? ~(bin_m[k] == 3) : (bin_m[k] == 3));
        end

        repeat (6) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (q[k].size() != 0) begin
                bad++;
                $display("FAIL drain inst%0d got %0d pending expectations, want 0", k, q[k].size());
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
